// File: rtl/mux_2to1_arbiter.sv
// Two-requester arbiter for a shared 2:1 mux path. Ties are broken by a
// last-owner bit, each grant is bounded by MAX_HOLD, and every release passes through IDLE.
module mux_2to1_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  output logic grant_a,
  output logic grant_b,
  output logic sel,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    GRANT_A = 3'b010,
    GRANT_B = 3'b100
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state;
  logic       last_owner;
  logic [7:0] count;
  logic       at_limit;

  assign at_limit = (count == HOLD_LIMIT);

  // last_owner: 1 = A owned the most recent grant, 0 = B.
  // The counter saturates at the limit, so a lone requester keeps its grant indefinitely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_a    <= 1'b0;
      grant_b    <= 1'b0;
      sel        <= 1'b0;
      busy       <= 1'b0;
      last_owner <= 1'b0;
      count      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a && (!req_b || !last_owner)) begin
            state   <= GRANT_A;
            grant_a <= 1'b1;
            grant_b <= 1'b0;
            sel     <= 1'b1;
            busy    <= 1'b1;
            count   <= 8'd0;
          end else if (req_b) begin
            state   <= GRANT_B;
            grant_a <= 1'b0;
            grant_b <= 1'b1;
            sel     <= 1'b0;
            busy    <= 1'b1;
            count   <= 8'd0;
          end
        end
        GRANT_A: begin
          if (!req_a || done || (at_limit && req_b)) begin
            state      <= IDLE;
            grant_a    <= 1'b0;
            busy       <= 1'b0;
            last_owner <= 1'b1;
          end else if (!at_limit) begin
            count <= count + 8'd1;
          end
        end
        GRANT_B: begin
          if (!req_b || done || (at_limit && req_a)) begin
            state      <= IDLE;
            grant_b    <= 1'b0;
            busy       <= 1'b0;
            last_owner <= 1'b0;
          end else if (!at_limit) begin
            count <= count + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_2to1_arbiter.md
MUX_2TO1_ARBITER -- requirements
Module: mux_2to1_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the maximum number of consecutive granted cycles while the other requester waits; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req_a  input  1  requester A asks for the shared 2:1 mux path (A is the sel=1 input).
REQ-005 req_b  input  1  requester B asks for the shared 2:1 mux path (B is the sel=0 input).
REQ-006 done  input  1  the current owner releases early; ignored in IDLE.
REQ-007 grant_a  output  1  registered; A owns the path.
REQ-008 grant_b  output  1  registered; B owns the path.
REQ-009 sel  output  1  registered mux select: 1 = A, 0 = B.
REQ-010 busy  output  1  registered; high in GRANT_A or GRANT_B.

Function
REQ-011 FSM states SHALL be IDLE, GRANT_A and GRANT_B, with one-hot-safe decoding; any illegal encoding SHALL return to IDLE on the next edge.
REQ-012 IDLE with only req_a high -> GRANT_A next cycle; only req_b high -> GRANT_B next cycle; neither high -> stay in IDLE.
REQ-013 IDLE with both requests high -> grant the requester that did not own the most recent grant, tracked by a 1-bit last_owner register; after reset last_owner = B, so A wins the first tie.
REQ-014 Grant latency SHALL be exactly 1 cycle: a request sampled at edge N in IDLE produces grant asserted after edge N.
REQ-015 In GRANT_x the grant SHALL hold while req_x is high, done is low and the hold limit is not reached.
REQ-016 GRANT_x -> IDLE when req_x is low, or done is high, or the timeout condition holds; last_owner <- x on that transition.
REQ-017 Timeout: an 8-bit hold counter SHALL clear on entry to a GRANT state and increment each granted cycle; timeout = (count == MAX_HOLD-1) and the other request is high.
REQ-018 If the other request is low at the hold limit, the counter SHALL saturate at MAX_HOLD-1 and the grant SHALL continue; it SHALL not wrap.
REQ-019 Every release SHALL pass through IDLE for at least 1 cycle as a guard cycle: no direct GRANT_A <-> GRANT_B transition.
REQ-020 grant_a and grant_b SHALL never be high together.
REQ-021 sel SHALL be 1 in GRANT_A and 0 in GRANT_B, and SHALL hold its last value in IDLE.
REQ-022 sel SHALL change only on the edge that enters a GRANT state, so it is stable before and throughout each grant.
REQ-023 busy SHALL equal grant_a OR grant_b.
REQ-024 done and a request drop in the same cycle SHALL be treated as a single release with no extra cycles.

Reset
REQ-025 With rst_n low at an edge, the block SHALL enter IDLE with grant_a=0, grant_b=0, sel=0, busy=0, last_owner=B and count=0, regardless of the requests.
REQ-026 Reset asserted mid-grant SHALL drop the grant on that same edge.
REQ-027 The first arbitration SHALL occur on the first edge with rst_n high.
REQ-028 Reset SHALL not act asynchronously: output changes only at clk edges.

Verification
REQ-029 Tie after reset: req_a=req_b=1 from the first active edge -> grant_a=1 and sel=1 after 1 cycle; with MAX_HOLD=4, grant_a drops after 4 granted cycles; 1 IDLE cycle; then grant_b=1 and sel=0.
REQ-030 Single requester: req_b held for 40 cycles with MAX_HOLD=16 and req_a=0 -> grant_b stays high continuously for 40 cycles, count saturates at 15, no guard cycle is inserted.
REQ-031 Early release: grant_a active, done pulsed for 1 cycle at granted cycle 2 -> IDLE on the next edge; sel stays 1 in IDLE; a pending req_b is granted 1 cycle later.
REQ-032 Reset mid-grant: grant_b active, rst_n low for 1 cycle -> grant_b=0, sel=0, busy=0 on that edge; with both requests high after release, A is granted first.
REQ-033 Alternation: req_a and req_b held high for 200 cycles with MAX_HOLD=3 -> strict A,B,A,B grant order, each grant lasting exactly 3 cycles, each separated by exactly 1 IDLE cycle, and grant_a&grant_b never high.
